// File: rtl/tl_pkg.sv
// tl_pkg: shared TileLink-UL definitions.
//   - A/D channel opcode encodings used by the RAM slave.
//   - Default fabric widths (must track tl_params.vh).
package tl_pkg;

  localparam int TL_DW  = 64;
  localparam int TL_AW  = 32;
  localparam int TL_SZW = 3;
  localparam int TL_AIW = 4;
  localparam int TL_DIW = 4;

  typedef enum logic [2:0] {
    TL_A_PUTFULL    = 3'd0,
    TL_A_PUTPARTIAL = 3'd1,
    TL_A_GET        = 3'd4
  } tl_a_op_e;

  typedef enum logic [3:0] {
    TL_D_ACCESSACK     = 4'd0,
    TL_D_ACCESSACKDATA = 4'd1
  } tl_d_op_e;

  function automatic logic tl_is_put(input logic [2:0] op);
    return (op == TL_A_PUTFULL) || (op == TL_A_PUTPARTIAL);
  endfunction

endpackage

// File: rtl/tl_ram_array.sv
// tl_ram_array: DEPTH x DW word storage, byte-masked write, synchronous read.
// Optional per-word poison bit when TL_RAM_CORRUPT_EN is defined.
// Ports:
//   clk, rst            clock, async active-high reset (poison bits only)
//   en                  read strobe; rd_data/rd_poison update only when set
//   we, idx, wmask      write strobe, word index, byte enables
//   wdata, wpoison      write data and poison value
//   rd_data, rd_poison  registered read of word idx
module tl_ram_array #(
  parameter int DW    = 64,
  parameter int DEPTH = 1024,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            we,
  input  logic [IW-1:0]   idx,
  input  logic [DW/8-1:0] wmask,
  input  logic [DW-1:0]   wdata,
  input  logic            wpoison,
  output logic [DW-1:0]   rd_data,
  output logic            rd_poison
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data_q;

  // Storage is intentionally not reset: contents survive rst.
  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++) begin
      if (we && wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Read register only moves on a strobe so a stalled response stays stable.
  always_ff @(posedge clk) begin
    if (en) rd_data_q <= mem[idx];
  end

  assign rd_data = rd_data_q;

`ifdef TL_RAM_CORRUPT_EN
  logic [DEPTH-1:0] poison_q, poison_d;
  logic             rd_poison_q;

  always_comb begin
    poison_d = poison_q;
    if (we) poison_d[idx] = wpoison;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poison_q    <= '0;
      rd_poison_q <= 1'b0;
    end else begin
      poison_q <= poison_d;
      if (en) rd_poison_q <= poison_q[idx];
    end
  end

  assign rd_poison = rd_poison_q;
`else
  logic unused_poison;
  assign unused_poison = ^{rst, wpoison};
  assign rd_poison     = 1'b0;
`endif

endmodule

// File: rtl/tl_ram_slave.sv
// tl_ram_slave: TileLink-UL slave terminating Get / PutFullData / PutPartialData
// on an on-chip RAM, with one registered D-channel response stage.
// Config macro: TL_RAM_CORRUPT_EN enables per-word poison (a_corrupt -> d_corrupt).
// Ports:
//   clk, rst                 clock, async active-high reset
//   a_valid/a_ready, a_*     Channel A request
//   d_valid/d_ready, d_*     Channel D response
module tl_ram_slave
  import tl_pkg::*;
#(
  parameter int             DW    = TL_DW,
  parameter int             AW    = TL_AW,
  parameter int             SZW   = TL_SZW,
  parameter int             AIW   = TL_AIW,
  parameter int             DIW   = TL_DIW,
  parameter int             DEPTH = 1024,
  parameter logic [AW-1:0]  BASE  = 'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [2:0]      a_opcode,
  input  logic [2:0]      a_param,
  input  logic [SZW-1:0]  a_size,
  input  logic [AIW-1:0]  a_source,
  input  logic [AW-1:0]   a_address,
  input  logic [DW/8-1:0] a_mask,
  input  logic [DW-1:0]   a_data,
  input  logic            a_corrupt,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [3:0]      d_opcode,
  output logic [1:0]      d_param,
  output logic [SZW-1:0]  d_size,
  output logic [AIW-1:0]  d_source,
  output logic [DIW-1:0]  d_sink,
  output logic            d_denied,
  output logic [DW-1:0]   d_data,
  output logic            d_corrupt
);

  localparam int            OB   = $clog2(DW/8);
  localparam int            IW   = $clog2(DEPTH);
  localparam logic [AW-1:0] SPAN = AW'(DEPTH * (DW/8));

  typedef struct packed {
    logic [3:0]     opcode;
    logic [SZW-1:0] size;
    logic [AIW-1:0] source;
    logic           denied;
    logic           data_ok;  // non-denied Get: drive RAM data/poison
  } rsp_t;

  rsp_t  rsp_q, rsp_d;
  logic  d_valid_q, d_valid_d;

  logic          a_fire, op_put, op_get, denied, we;
  logic [AW-1:0] offset, align_mask;
  logic [IW-1:0] word_idx;
  logic [DW-1:0] rd_data;
  logic          rd_poison, wpoison;

  assign a_ready = !d_valid_q || d_ready;
  assign a_fire  = a_valid && a_ready;

  // Decode
  assign offset     = a_address - BASE;
  assign align_mask = (AW'(1) << a_size) - AW'(1);
  assign op_put     = tl_is_put(a_opcode);
  assign op_get     = (a_opcode == TL_A_GET);
  assign denied     = !((a_address >= BASE) && (offset < SPAN) &&
                        (a_size <= SZW'(OB)) &&
                        ((a_address & align_mask) == '0) &&
                        (op_put || op_get));
  assign word_idx   = offset[OB +: IW];
  assign we         = a_fire && op_put && !denied;

`ifdef TL_RAM_CORRUPT_EN
  assign wpoison = a_corrupt;
`else
  logic unused_corrupt;
  assign unused_corrupt = a_corrupt;
  assign wpoison        = 1'b0;
`endif

  logic unused_a;
  assign unused_a = ^{a_param, offset};

  tl_ram_array #(.DW(DW), .DEPTH(DEPTH), .IW(IW)) u_array (
    .clk       (clk),
    .rst       (rst),
    .en        (a_fire),
    .we        (we),
    .idx       (word_idx),
    .wmask     (a_mask),
    .wdata     (a_data),
    .wpoison   (wpoison),
    .rd_data   (rd_data),
    .rd_poison (rd_poison)
  );

  // Response register: reload on A fire (also covers simultaneous D fire),
  // otherwise drop valid once D fires.
  always_comb begin
    rsp_d     = rsp_q;
    d_valid_d = d_valid_q;
    if (a_fire) begin
      rsp_d.opcode  = op_put ? TL_D_ACCESSACK : TL_D_ACCESSACKDATA;
      rsp_d.size    = a_size;
      rsp_d.source  = a_source;
      rsp_d.denied  = denied;
      rsp_d.data_ok = op_get && !denied;
      d_valid_d     = 1'b1;
    end else if (d_ready) begin
      d_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q     <= '0;
      d_valid_q <= 1'b0;
    end else begin
      rsp_q     <= rsp_d;
      d_valid_q <= d_valid_d;
    end
  end

  assign d_valid   = d_valid_q;
  assign d_opcode  = rsp_q.opcode;
  assign d_param   = '0;
  assign d_size    = rsp_q.size;
  assign d_source  = rsp_q.source;
  assign d_sink    = '0;
  assign d_denied  = rsp_q.denied;
  assign d_data    = rsp_q.data_ok ? rd_data : '0;
  assign d_corrupt = rsp_q.data_ok && rd_poison;

endmodule

// File: tb/tb_tl_ram_slave.sv
// tb_tl_ram_slave: randomized + directed bench for tl_ram_slave with a
// word-array reference model and an expected-response queue.
module tb_tl_ram_slave;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, a_corrupt;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;
  logic        d_valid, d_ready, d_denied, d_corrupt;
  logic [3:0]  d_opcode, d_source, d_sink;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [63:0] d_data;

  always #5 clk = ~clk;

  tl_ram_slave dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied),
    .d_data(d_data), .d_corrupt(d_corrupt)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model
  typedef struct {
    logic [3:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic        den;
    logic [63:0] data;
    bit          chk_data;
    logic        cor;
    bit          chk_cor;
  } exp_t;

  logic [63:0] mem_m [DEPTH];
  bit          known [DEPTH];
  bit          pois  [DEPTH];
  exp_t        q[$];
  logic [63:0] last_d_data;
  logic        last_d_denied, last_d_corrupt;
  int          dfires = 0;

  task automatic model_fire();
    exp_t e;
    longint unsigned a;
    bit den, put, get;
    int idx;
    a   = longint'(a_address);
    put = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    get = (a_opcode == 3'd4);
    den = (a < BASE) || (a >= longint'(BASE) + DEPTH * 8) || (a_size > 3) ||
          ((a % (64'd1 << a_size)) != 0) || !(put || get);
    idx = den ? 0 : int'((a - BASE) / 8);
    e.op = put ? 4'd0 : 4'd1;
    e.size = a_size; e.src = a_source; e.den = den;
    e.data = '0; e.chk_data = 1'b1; e.cor = 1'b0; e.chk_cor = 1'b1;
    if (!den && put) begin
      for (int b = 0; b < 8; b++)
        if (a_mask[b]) mem_m[idx][8*b +: 8] = a_data[8*b +: 8];
      if (a_mask == 8'hFF) known[idx] = 1'b1;
      pois[idx] = a_corrupt;
      e.chk_data = 1'b0;
    end
    if (!den && get) begin
      e.data = mem_m[idx];
      e.chk_data = known[idx];
`ifdef TL_RAM_CORRUPT_EN
      e.cor = pois[idx];
`endif
    end
`ifdef TL_RAM_CORRUPT_EN
    e.chk_cor = !den && get;
`endif
    q.push_back(e);
  endtask

  // One clock: check outputs at negedge+1, advance model, return at posedge+1.
  task automatic step();
    bit   exp_rdy;
    exp_t e;
    @(negedge clk); #1;
    exp_rdy = (q.size() == 0) || d_ready;
    chk("d_valid", d_valid, q.size() != 0);
    chk("a_ready", a_ready, exp_rdy);
    if (q.size() != 0) begin
      e = q[0];
      chk("d_opcode", d_opcode, e.op);
      chk("d_source", d_source, e.src);
      chk("d_size", d_size, e.size);
      chk("d_denied", d_denied, e.den);
      chk("d_param", d_param, 0);
      chk("d_sink", d_sink, 0);
      if (e.chk_data) chk("d_data", d_data, e.data);
      if (e.chk_cor) chk("d_corrupt", d_corrupt, e.cor);
      if (d_ready) begin
        last_d_data = d_data; last_d_denied = d_denied; last_d_corrupt = d_corrupt;
        dfires++;
        e = q.pop_front();
      end
    end
    if (a_valid && exp_rdy) model_fire();
    @(posedge clk); #1;
  endtask

  task automatic set_a(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                       input logic [31:0] addr, input logic [7:0] mask,
                       input logic [63:0] data, input logic cor);
    a_valid = 1'b1; a_opcode = op; a_size = sz; a_source = src;
    a_address = addr; a_mask = mask; a_data = data; a_corrupt = cor;
    a_param = 3'($urandom);
  endtask

  task automatic req(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                     input logic [31:0] addr, input logic [7:0] mask,
                     input logic [63:0] data, input logic cor);
    set_a(op, sz, src, addr, mask, data, cor);
    step();
    a_valid = 1'b0;
  endtask

  initial begin
    int d0;
    logic [63:0] keep;
    rst = 1'b1; a_valid = 0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
    a_address = 0; a_mask = 0; a_data = 0; a_corrupt = 0; d_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin known[i] = 0; pois[i] = 0; mem_m[i] = 0; end
    #12;
    chk("rst_d_valid", d_valid, 0);
    chk("rst_d_opcode", d_opcode, 0);
    chk("rst_d_data", d_data, 0);
    chk("rst_d_denied", d_denied, 0);
    chk("rst_a_ready", a_ready, 1);
    @(posedge clk); #1; rst = 1'b0; d_ready = 1'b1;

    // Full / partial write and read-back
    req(3'd0, 3, 4'd2, BASE, 8'hFF, 64'h1122334455667788, 0);
    req(3'd4, 3, 4'd0, BASE, 8'h00, 64'h0, 0);
    step();
    chk("pf_get_data", last_d_data, 64'h1122334455667788);
    req(3'd1, 3, 4'd1, BASE, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 0);
    req(3'd4, 3, 4'd3, BASE, 8'h00, 64'h0, 0);
    step();
    chk("pp_get_data", last_d_data, 64'h11223344BBBBBBBB);

    // Denied requests
    req(3'd4, 3, 4'd4, 32'h7FFF_FFF8, 8'hFF, 0, 0); step();
    chk("den_below", last_d_denied, 1); chk("den_below_data", last_d_data, 0);
    req(3'd4, 3, 4'd5, BASE + DEPTH * 8, 8'hFF, 0, 0); step();
    chk("den_above", last_d_denied, 1); chk("den_above_data", last_d_data, 0);
    req(3'd4, 2, 4'd6, BASE + 2, 8'hFF, 0, 0); step();
    chk("den_align", last_d_denied, 1);
    req(3'd2, 3, 4'd7, BASE, 8'hFF, 64'hDEAD, 0); step();
    chk("den_opc", last_d_denied, 1);
    req(3'd0, 2, 4'd8, BASE + 2, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0); step();
    chk("den_put", last_d_denied, 1);
    req(3'd4, 3, 4'd9, BASE, 8'h00, 0, 0); step();
    chk("den_unchanged", last_d_data, 64'h11223344BBBBBBBB);

    // Initialise words used by random traffic
    for (int i = 0; i < 17; i++) begin
      int w;
      w = (i == 16) ? DEPTH - 1 : i;
      req(3'd0, 3, 4'(i), BASE + 32'(w * 8), 8'hFF, {$urandom, $urandom}, 1'($urandom));
    end
    step();

    // Backpressure then streaming
    d_ready = 1'b0;
    req(3'd4, 3, 4'd10, BASE + 8, 8'h00, 0, 0);
    set_a(3'd4, 3, 4'd11, BASE + 16, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step();
    d_ready = 1'b1;
    d0 = dfires;
    for (int i = 0; i < 8; i++) begin
      set_a(3'd4, 3, 4'(i), BASE + 32'(i * 8), 8'h00, 0, 0);
      step();
    end
    a_valid = 1'b0;
    step();
    chk("stream_cnt", dfires - d0, 9);
    step();

    // Poison
    req(3'd0, 3, 4'd1, BASE + 40, 8'hFF, 64'h55, 1);
    req(3'd4, 3, 4'd1, BASE + 40, 8'h00, 0, 0); step();
`ifdef TL_RAM_CORRUPT_EN
    chk("poison_set", last_d_corrupt, 1);
`else
    chk("poison_off", last_d_corrupt, 0);
`endif
    req(3'd0, 3, 4'd1, BASE + 40, 8'hFF, 64'h66, 0);
    req(3'd4, 3, 4'd1, BASE + 40, 8'h00, 0, 0); step();
    chk("poison_clr", last_d_corrupt, 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [2:0]  op, sz;
      logic [31:0] addr;
      int r, w, off;
      r  = $urandom % 10;
      op = (r < 4) ? 3'd4 : (r < 7) ? 3'($urandom % 2) : 3'($urandom);
      sz = ($urandom % 10 < 8) ? 3'($urandom % 4) : 3'($urandom);
      w  = ($urandom % 17 == 16) ? DEPTH - 1 : int'($urandom % 16);
      off = int'($urandom % 8);
      if (($urandom % 10 < 7) && sz <= 3) off = off & ~((1 << sz) - 1);
      addr = BASE + 32'(w * 8 + off);
      case ($urandom % 12)
        0: addr = BASE - 8;
        1: addr = BASE + DEPTH * 8;
        2: addr = $urandom;
        default: ;
      endcase
      set_a(op, sz, 4'($urandom), addr, 8'($urandom), {$urandom, $urandom}, 1'($urandom));
      a_valid = ($urandom % 4) != 0;
      d_ready = ($urandom % 10) < 7;
      step();
    end
    a_valid = 1'b0; d_ready = 1'b1;
    step(); step();

    // Reset during a stalled response
    d_ready = 1'b0;
    keep = 64'hCAFE_F00D_1234_5678;
    req(3'd0, 3, 4'd3, BASE + 24, 8'hFF, keep, 1);
    #2 rst = 1'b1;
    #1 chk("rst_async_dvalid", d_valid, 0);
    q.delete();
    for (int i = 0; i < DEPTH; i++) pois[i] = 0;
    @(posedge clk); #1; rst = 1'b0; d_ready = 1'b1;
    req(3'd4, 3, 4'd3, BASE + 24, 8'h00, 0, 0); step();
    chk("rst_keep_data", last_d_data, keep);
    chk("rst_poison_clr", last_d_corrupt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end

endmodule
